// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus: picks one finished functional
// unit per cycle and registers its ROB tag, result and source index for broadcast.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
  localparam int unsigned SUM_W = SRC_W + 1;

  logic [SRC_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q,   cdb_src_d;

  logic              grant_any;
  logic [SRC_W-1:0]  grant_idx;
  logic [SUM_W-1:0]  cand;
  logic              arb_en;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_data;
  logic [SRC_W-1:0]  rr_next;

  // First valid unit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SUM_W'(rr_ptr_q) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!grant_any && req_valid[cand[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  // The bus only accepts a winner when nothing is squashing or holding it.
  assign arb_en = !reset && !flush && !cdb_stall;

  always_comb begin
    req_ready = '0;
    if (arb_en && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_tag  = req_tag[grant_idx*TAG_W +: TAG_W];
  assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];
  assign rr_next    = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  // Flush beats stall beats grant; stall freezes every broadcast field.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (cdb_stall) begin
      cdb_valid_d = cdb_valid_q;
    end else if (grant_any) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = grant_tag;
      cdb_data_d  = grant_data;
      cdb_src_d   = grant_idx;
      rr_ptr_d    = rr_next;
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: the driver queues hand-computed per-cycle
// and per-broadcast expectations, a negedge monitor pops and compares them.
module tb_cdb_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic                      cdb_stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .SRC_W   (SRC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .cdb_stall (cdb_stall),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] rdy;
    logic               vld;
    logic               chk0;
  } cyc_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } bcast_t;

  cyc_t   cyc_q[$];
  bcast_t bcast_q[$];

  logic [TAG_W-1:0]  utag  [NUM_REQ];
  logic [DATA_W-1:0] udata [NUM_REQ];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_unit(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    utag[i]  = t;
    udata[i] = d;
  endtask

  task automatic exp_unit(input int i);
    bcast_t b;
    b.tag  = utag[i];
    b.data = udata[i];
    b.src  = SRC_W'(i);
    bcast_q.push_back(b);
  endtask

  // Drive one cycle of inputs and queue the values expected during that cycle.
  task automatic cyc(input logic [NUM_REQ-1:0] v, input logic st, input logic fl,
                     input logic rs, input logic [NUM_REQ-1:0] er, input logic ev,
                     input logic c0);
    cyc_t c;
    req_valid = v;
    cdb_stall = st;
    flush     = fl;
    reset     = rs;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = utag[i];
      req_data[i*DATA_W +: DATA_W] = udata[i];
    end
    c.rdy  = er;
    c.vld  = ev;
    c.chk0 = c0;
    cyc_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle checks plus broadcast consumption when the bus is accepted.
  logic [NUM_REQ-1:0] prev_v, prev_r;
  logic               prev_rst;
  logic               have_prev = 1'b0;

  always @(negedge clk) begin
    cyc_t   c;
    bcast_t b;
    if (cyc_q.size() != 0) begin
      c = cyc_q.pop_front();
      chk("req_ready", 32'(req_ready), 32'(c.rdy));
      chk("cdb_valid", 32'(cdb_valid), 32'(c.vld));
      if (c.chk0) begin
        chk("cdb_tag_zero",  32'(cdb_tag),  32'd0);
        chk("cdb_data_zero", cdb_data,      32'd0);
        chk("cdb_src_zero",  32'(cdb_src),  32'd0);
      end
      if (cdb_valid === 1'b1 && !cdb_stall && !flush && !reset) begin
        if (bcast_q.size() == 0) begin
          chk("unexpected_bcast", 32'(cdb_src), 32'hFFFF_FFFF);
        end else begin
          b = bcast_q.pop_front();
          chk("bcast_tag",  32'(cdb_tag), 32'(b.tag));
          chk("bcast_data", cdb_data,     b.data);
          chk("bcast_src",  32'(cdb_src), 32'(b.src));
        end
      end
      if (have_prev && !reset && !prev_rst) begin
        assert (((prev_v & ~prev_r) & ~req_valid) == '0)
          else $error("requester dropped valid without a grant at %0t", $time);
      end
      prev_v    <= req_valid;
      prev_r    <= req_ready;
      prev_rst  <= reset;
      have_prev <= 1'b1;
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      set_unit(i, TAG_W'(5'h10 + i), 32'hA5A5_0000 | 32'(i));
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state: everything zero, no grant while reset is high.
    cyc(4'b0000, 0, 0, 1, 4'b0000, 0, 1);

    // T1 single request from unit 2.
    set_unit(2, 5'h0A, 32'hDEADBEEF);
    exp_unit(2);
    cyc(4'b0100, 0, 0, 0, 4'b0100, 0, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    // T3 wrap: rr_ptr is 3, units 0 and 3 valid.
    set_unit(0, 5'h01, 32'h1111_0000);
    set_unit(3, 5'h13, 32'h3333_0003);
    exp_unit(3);
    cyc(4'b1001, 0, 0, 0, 4'b1000, 0, 0);
    exp_unit(0);
    cyc(4'b0001, 0, 0, 0, 4'b0001, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    // rr_ptr must now be 1: units 0 and 1 valid picks unit 1.
    set_unit(1, 5'h11, 32'h2222_0001);
    exp_unit(1);
    cyc(4'b0011, 0, 0, 0, 4'b0010, 0, 0);
    exp_unit(0);
    cyc(4'b0001, 0, 0, 0, 4'b0001, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    // T4 stall for 3 cycles during a burst starting at rr_ptr=1.
    set_unit(2, 5'h12, 32'hCCCC_0002);
    exp_unit(1);
    cyc(4'b1111, 0, 0, 0, 4'b0010, 0, 0);
    exp_unit(2);
    cyc(4'b1101, 0, 0, 0, 4'b0100, 1, 0);
    cyc(4'b1001, 1, 0, 0, 4'b0000, 1, 0);
    cyc(4'b1001, 1, 0, 0, 4'b0000, 1, 0);
    cyc(4'b1001, 1, 0, 0, 4'b0000, 1, 0);
    exp_unit(3);
    cyc(4'b1001, 0, 0, 0, 4'b1000, 1, 0);
    exp_unit(0);
    cyc(4'b0001, 0, 0, 0, 4'b0001, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    // T5 flush together with stall while a broadcast is on the bus.
    // The unit-1 broadcast is squashed, so it is not queued.
    cyc(4'b0110, 0, 0, 0, 4'b0010, 0, 0);
    cyc(4'b0100, 1, 1, 0, 4'b0000, 1, 0);
    // rr_ptr still 2: with units 1,2,3 valid, unit 2 wins.
    set_unit(1, 5'h15, 32'h5555_0001);
    exp_unit(2);
    cyc(4'b1110, 0, 0, 0, 4'b0100, 0, 0);
    exp_unit(3);
    cyc(4'b1010, 0, 0, 0, 4'b1000, 1, 0);
    exp_unit(1);
    cyc(4'b0010, 0, 0, 0, 4'b0010, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    // T2 contention from reset: order 0,1,2,3 then idle.
    cyc(4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    exp_unit(0);
    cyc(4'b1111, 0, 0, 0, 4'b0001, 0, 1);
    exp_unit(1);
    cyc(4'b1110, 0, 0, 0, 4'b0010, 1, 0);
    exp_unit(2);
    cyc(4'b1100, 0, 0, 0, 4'b0100, 1, 0);
    exp_unit(3);
    cyc(4'b1000, 0, 0, 0, 4'b1000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    // T6 reset mid-burst: the unit-1 grant is lost, order restarts at unit 0.
    exp_unit(0);
    cyc(4'b1111, 0, 0, 0, 4'b0001, 0, 0);
    cyc(4'b1110, 0, 0, 0, 4'b0010, 1, 0);
    cyc(4'b0000, 0, 0, 1, 4'b0000, 1, 0);
    exp_unit(0);
    cyc(4'b1111, 0, 0, 0, 4'b0001, 0, 1);
    exp_unit(1);
    cyc(4'b1110, 0, 0, 0, 4'b0010, 1, 0);
    exp_unit(2);
    cyc(4'b1100, 0, 0, 0, 4'b0100, 1, 0);
    exp_unit(3);
    cyc(4'b1000, 0, 0, 0, 4'b1000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    cyc(4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    @(negedge clk);
    #1;
    chk("bcast_q_drained", 32'(bcast_q.size()), 32'd0);
    chk("cyc_q_drained",   32'(cyc_q.size()),   32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
